maze_row_sched: RTL and testbench

- Sequences a single-port 30x40-bit maze map RAM shared by two requesters: the VGA draw path and game logic (maze generator, player collision checks).
- In each horizontal blank it fetches the map row for the next visible line into a shadow register, then presents it as a stable 40-bit row for that entire line.
- Game logic gets the RAM whenever no display fetch is pending or in flight.
- Sits between the VGA timing counters, the map RAM and the draw/colour logic.

---
 rtl/maze_pkg.sv | 50 +++++
 rtl/maze_line_tracker.sv | 58 +++++
 rtl/maze_row_sched.sv | 129 ++++++++++++
 tb/tb_maze_row_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants, encodings and helpers for the maze map row scheduler.
package maze_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int FETCH_H  = 640;
  localparam int MAP_ROWS = 30;
  localparam int MAP_COLS = 40;

  typedef enum logic [1:0] {
    LVL_EASY   = 2'd0,
    LVL_NORMAL = 2'd1,
    LVL_HARD   = 2'd2
  } level_t;

  localparam logic [5:0] CELL_H_EASY   = 6'd40;
  localparam logic [5:0] CELL_H_NORMAL = 6'd20;
  localparam logic [5:0] CELL_H_HARD   = 6'd16;
  localparam logic [4:0] ROWS_EASY     = 5'd12;
  localparam logic [4:0] ROWS_NORMAL   = 5'd24;
  localparam logic [4:0] ROWS_HARD     = 5'd30;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DISP_RD   = 3'd1,
    ST_DISP_WAIT = 3'd2,
    ST_GAME_ACC  = 3'd3,
    ST_GAME_WAIT = 3'd4
  } state_t;

  function automatic logic [5:0] cell_height(input level_t lvl);
    case (lvl)
      LVL_EASY:   return CELL_H_EASY;
      LVL_NORMAL: return CELL_H_NORMAL;
      default:    return CELL_H_HARD;
    endcase
  endfunction

  // The unused encoding 11 behaves as the hardest level.
  function automatic level_t decode_level(input logic [1:0] raw);
    case (raw)
      2'b00:   return LVL_EASY;
      2'b01:   return LVL_NORMAL;
      default: return LVL_HARD;
    endcase
  endfunction

endpackage

// File: rtl/maze_line_tracker.sv
// Tracks which maze row the next visible line needs and strobes the fetch request.
module maze_line_tracker
  import maze_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_HPos,
  input  logic [9:0] i_VPos,
  input  logic [1:0] i_MazeLevel,
  output logic       o_FetchStb,
  output logic [4:0] o_RowNext,
  output logic [4:0] o_Row
);

  logic [9:0] next_line;
  level_t     level_reg, level_next;
  logic [5:0] sub_reg, sub_next;
  logic [4:0] row_reg, row_next;
  logic       fetch_stb;

  always_comb begin
    next_line  = (i_VPos == 10'(V_TOTAL - 1)) ? 10'd0 : i_VPos + 10'd1;
    fetch_stb  = (i_HPos == 10'(FETCH_H)) && (next_line < 10'(V_ACTIVE));
    level_next = level_reg;
    sub_next   = sub_reg;
    row_next   = row_reg;
    if (fetch_stb) begin
      if (next_line == 10'd0) begin
        level_next = decode_level(i_MazeLevel);
        sub_next   = 6'd0;
        row_next   = 5'd0;
      end else if (sub_reg + 6'd1 == cell_height(level_reg)) begin
        sub_next = 6'd0;
        row_next = row_reg + 5'd1;
      end else begin
        sub_next = sub_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      level_reg <= LVL_EASY;
      sub_reg   <= 6'd0;
      row_reg   <= 5'd0;
    end else begin
      level_reg <= level_next;
      sub_reg   <= sub_next;
      row_reg   <= row_next;
    end
  end

  // The row seen by a fetch issued this cycle must include this cycle's update.
  assign o_FetchStb = fetch_stb;
  assign o_RowNext  = row_next;
  assign o_Row      = row_reg;

endmodule

// File: rtl/maze_row_sched.sv
// Arbitrates the single-port maze RAM between per-line display fetches and game
// logic, and presents a stable row for each visible line.
module maze_row_sched
  import maze_pkg::*;
(
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [9:0]          i_HPos,
  input  logic [9:0]          i_VPos,
  input  logic [1:0]          i_MazeLevel,
  input  logic                i_GReq,
  input  logic                i_GWe,
  input  logic [4:0]          i_GRow,
  input  logic [MAP_COLS-1:0] i_GData,
  output logic                o_GAck,
  output logic [MAP_COLS-1:0] o_GRdData,
  output logic                o_MemEn,
  output logic                o_MemWe,
  output logic [4:0]          o_MemAddr,
  output logic [MAP_COLS-1:0] o_MemWData,
  input  logic [MAP_COLS-1:0] i_MemRData,
  output logic [MAP_COLS-1:0] o_RowBits,
  output logic [4:0]          o_RowIdx
);

  logic                fetch_stb;
  logic [4:0]          row_next;
  logic [4:0]          row_cur;
  state_t              state_reg;
  logic                pending_reg;
  logic                fetched_reg;
  logic                g_rd_valid_reg;
  logic [MAP_COLS-1:0] shadow_reg;
  logic [4:0]          shadow_idx_reg;
  logic                row_ok;

  maze_line_tracker u_line_tracker (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_HPos      (i_HPos),
    .i_VPos      (i_VPos),
    .i_MazeLevel (i_MazeLevel),
    .o_FetchStb  (fetch_stb),
    .o_RowNext   (row_next),
    .o_Row       (row_cur)
  );

  assign row_ok    = (i_GRow < 5'(MAP_ROWS));
  assign o_GRdData = (o_GAck && g_rd_valid_reg) ? i_MemRData : '0;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_reg      <= ST_IDLE;
      pending_reg    <= 1'b0;
      fetched_reg    <= 1'b0;
      g_rd_valid_reg <= 1'b0;
      shadow_reg     <= '0;
      shadow_idx_reg <= 5'd0;
      o_GAck         <= 1'b0;
      o_MemEn        <= 1'b0;
      o_MemWe        <= 1'b0;
      o_MemAddr      <= 5'd0;
      o_MemWData     <= '0;
      o_RowBits      <= '0;
      o_RowIdx       <= 5'd0;
    end else begin
      o_MemEn    <= 1'b0;
      o_MemWe    <= 1'b0;
      o_MemAddr  <= 5'd0;
      o_MemWData <= '0;
      o_GAck     <= 1'b0;
      if (fetch_stb) pending_reg <= 1'b1;

      // RAM controls are registered, so they are loaded on entry to the access state.
      case (state_reg)
        ST_IDLE: begin
          if (pending_reg || fetch_stb) begin
            state_reg <= ST_DISP_RD;
            o_MemEn   <= 1'b1;
            o_MemAddr <= row_next;
          end else if (i_GReq) begin
            state_reg      <= ST_GAME_ACC;
            g_rd_valid_reg <= row_ok && !i_GWe;
            if (row_ok) begin
              o_MemEn    <= 1'b1;
              o_MemWe    <= i_GWe;
              o_MemAddr  <= i_GRow;
              o_MemWData <= i_GData;
            end
          end
        end
        ST_DISP_RD: begin
          pending_reg <= 1'b0;
          state_reg   <= ST_DISP_WAIT;
        end
        ST_DISP_WAIT: begin
          shadow_reg     <= i_MemRData;
          shadow_idx_reg <= row_cur;
          fetched_reg    <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        ST_GAME_ACC: begin
          o_GAck    <= 1'b1;
          state_reg <= ST_GAME_WAIT;
        end
        ST_GAME_WAIT: begin
          // A fetch that arrived during the game access is issued without an idle gap.
          if (pending_reg || fetch_stb) begin
            state_reg <= ST_DISP_RD;
            o_MemEn   <= 1'b1;
            o_MemAddr <= row_next;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (i_HPos == 10'(H_TOTAL - 1)) begin
        if (fetched_reg) begin
          o_RowBits <= shadow_reg;
          o_RowIdx  <= shadow_idx_reg;
        end
        fetched_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maze_row_sched.sv
// Directed bench for maze_row_sched: drives VPos/HPos directly around the fetch
// point of each line and checks RAM traffic, game acks and committed rows.
module tb_maze_row_sched;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [9:0]  i_HPos, i_VPos;
  logic [1:0]  i_MazeLevel;
  logic        i_GReq, i_GWe;
  logic [4:0]  i_GRow;
  logic [39:0] i_GData;
  logic        o_GAck;
  logic [39:0] o_GRdData;
  logic        o_MemEn, o_MemWe;
  logic [4:0]  o_MemAddr;
  logic [39:0] o_MemWData;
  logic [39:0] i_MemRData;
  logic [39:0] o_RowBits;
  logic [4:0]  o_RowIdx;

  int total = 0;
  int bad = 0;
  int cur_h = 0;
  int cur_v = 0;
  int acc_n, ack_n, ack_h;
  logic [4:0]  acc_addr [8];
  logic        acc_we [8];
  int          acc_h [8];
  logic [39:0] ack_data;

  logic [39:0] ram_wdata [30];
  logic        ram_written [30];
  logic [39:0] rd_reg = '0;

  maze_row_sched dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_HPos(i_HPos), .i_VPos(i_VPos),
    .i_MazeLevel(i_MazeLevel), .i_GReq(i_GReq), .i_GWe(i_GWe), .i_GRow(i_GRow),
    .i_GData(i_GData), .o_GAck(o_GAck), .o_GRdData(o_GRdData), .o_MemEn(o_MemEn),
    .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData),
    .i_MemRData(i_MemRData), .o_RowBits(o_RowBits), .o_RowIdx(o_RowIdx)
  );

  always #5 i_Clk = ~i_Clk;

  // Unwritten RAM rows hold a recognisable per-row pattern.
  function automatic logic [39:0] pat(input int r);
    return {8'hA0 + 8'(r), 32'h0BAD0000 + 32'(r)};
  endfunction

  always @(posedge i_Clk) begin
    if (!i_Rst) begin
      for (int k = 0; k < 30; k++) ram_written[k] <= 1'b0;
    end else if (o_MemEn) begin
      if (o_MemWe) begin
        ram_wdata[o_MemAddr]   <= o_MemWData;
        ram_written[o_MemAddr] <= 1'b1;
      end
      rd_reg <= ram_written[o_MemAddr] ? ram_wdata[o_MemAddr] : pat(int'(o_MemAddr));
    end
  end
  assign i_MemRData = rd_reg;

  task automatic set_pos(input int h, input int v);
    cur_h = h; cur_v = v;
    i_HPos = 10'(h); i_VPos = 10'(v);
  endtask

  // Advance one clock; inputs and observations then belong to the new cycle.
  task automatic cyc();
    @(posedge i_Clk); #1;
    if (cur_h == 799) begin
      cur_h = 0;
      cur_v = (cur_v == 524) ? 0 : cur_v + 1;
    end else begin
      cur_h = cur_h + 1;
    end
    i_HPos = 10'(cur_h); i_VPos = 10'(cur_v);
    if (o_MemEn) begin
      if (acc_n < 8) begin
        acc_addr[acc_n] = o_MemAddr; acc_we[acc_n] = o_MemWe; acc_h[acc_n] = cur_h;
      end
      acc_n++;
    end
    if (o_GAck) begin
      ack_n++; ack_h = cur_h; ack_data = o_GRdData;
      i_GReq = 1'b0;
    end
  endtask

  task automatic do_line(input int v);
    set_pos(638, v);
    acc_n = 0; ack_n = 0;
    repeat (8) cyc();
    set_pos(799, v);
    cyc();
  endtask

  task automatic test_reset();
    i_Rst = 1'b0; i_MazeLevel = 2'b00; i_GReq = 1'b0; i_GWe = 1'b0;
    i_GRow = 5'd0; i_GData = '0;
    set_pos(0, 0);
    acc_n = 0; ack_n = 0;
    repeat (3) cyc();
    total++; if (o_MemEn !== 1'b0 || o_MemWe !== 1'b0 || o_MemAddr !== 5'd0 || o_MemWData !== 40'd0) begin
      bad++; $display("FAIL reset_mem got en=%b we=%b addr=%0d wd=%h want all 0", o_MemEn, o_MemWe, o_MemAddr, o_MemWData); end
    total++; if (o_GAck !== 1'b0 || o_GRdData !== 40'd0) begin
      bad++; $display("FAIL reset_game got ack=%b rd=%h want 0", o_GAck, o_GRdData); end
    total++; if (o_RowBits !== 40'd0 || o_RowIdx !== 5'd0) begin
      bad++; $display("FAIL reset_row got bits=%h idx=%0d want 0", o_RowBits, o_RowIdx); end
    i_Rst = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_easy_frame();
    i_MazeLevel = 2'b00;
    set_pos(638, 524); acc_n = 0;
    repeat (8) cyc();
    total++; if (acc_n !== 1 || acc_addr[0] !== 5'd0 || acc_we[0] !== 1'b0 || acc_h[0] !== 641) begin
      bad++; $display("FAIL easy_524_fetch got n=%0d addr=%0d we=%b h=%0d want n=1 addr=0 we=0 h=641",
                      acc_n, acc_addr[0], acc_we[0], acc_h[0]); end
    set_pos(798, 524);
    total++; if (o_RowBits !== 40'd0) begin
      bad++; $display("FAIL easy_hold_798 got %h want 0", o_RowBits); end
    cyc();
    total++; if (o_RowBits !== 40'd0) begin
      bad++; $display("FAIL easy_hold_799 got %h want 0", o_RowBits); end
    cyc();
    total++; if (o_RowBits !== pat(0) || o_RowIdx !== 5'd0) begin
      bad++; $display("FAIL easy_commit_line0 got %h/%0d want %h/0", o_RowBits, o_RowIdx, pat(0)); end
    for (int v = 0; v < 40; v++) begin
      do_line(v);
      if (v == 38) begin
        total++; if (acc_n !== 1 || acc_addr[0] !== 5'd0) begin
          bad++; $display("FAIL easy_fetch_line39 got n=%0d addr=%0d want 1/0", acc_n, acc_addr[0]); end
      end
      if (v == 39) begin
        total++; if (acc_n !== 1 || acc_addr[0] !== 5'd1) begin
          bad++; $display("FAIL easy_fetch_line40 got n=%0d addr=%0d want 1/1", acc_n, acc_addr[0]); end
      end
    end
    total++; if (o_RowBits !== pat(1) || o_RowIdx !== 5'd1) begin
      bad++; $display("FAIL easy_line40_row got %h/%0d want %h/1", o_RowBits, o_RowIdx, pat(1)); end
    $display("test_easy_frame: done");
  endtask

  task automatic test_hard_frame();
    int blank_acc;
    i_MazeLevel = 2'b11;
    do_line(524);
    for (int v = 0; v < 479; v++) begin
      do_line(v);
      total++; if (acc_n !== 1 || acc_addr[0] !== 5'((v + 1) / 16)) begin
        bad++; $display("FAIL hard_fetch v=%0d got n=%0d addr=%0d want 1/%0d", v, acc_n, acc_addr[0], (v + 1) / 16); end
    end
    total++; if (o_RowIdx !== 5'd29 || o_RowBits !== pat(29)) begin
      bad++; $display("FAIL hard_line479 got %h/%0d want %h/29", o_RowBits, o_RowIdx, pat(29)); end
    blank_acc = 0;
    for (int v = 479; v < 524; v++) begin
      do_line(v);
      blank_acc += acc_n;
    end
    total++; if (blank_acc !== 0) begin
      bad++; $display("FAIL hard_blank_access got %0d want 0", blank_acc); end
    total++; if (o_RowIdx !== 5'd29 || o_RowBits !== pat(29)) begin
      bad++; $display("FAIL hard_blank_hold got %h/%0d want %h/29", o_RowBits, o_RowIdx, pat(29)); end
    $display("test_hard_frame: done");
  endtask

  task automatic test_game_collide();
    set_pos(638, 50); acc_n = 0; ack_n = 0; i_GReq = 1'b0;
    cyc();
    i_GReq = 1'b1; i_GWe = 1'b0; i_GRow = 5'd5;
    repeat (7) cyc();
    total++; if (acc_n !== 2 || acc_addr[0] !== 5'd5 || acc_we[0] !== 1'b0 || acc_h[0] !== 640) begin
      bad++; $display("FAIL collide_game_acc got n=%0d addr=%0d we=%b h=%0d want 2/5/0/640", acc_n, acc_addr[0], acc_we[0], acc_h[0]); end
    total++; if (ack_n !== 1 || ack_h !== 641 || ack_data !== pat(5)) begin
      bad++; $display("FAIL collide_ack got n=%0d h=%0d d=%h want 1/641/%h", ack_n, ack_h, ack_data, pat(5)); end
    total++; if (acc_addr[1] !== 5'd2 || acc_we[1] !== 1'b0 || acc_h[1] !== 642) begin
      bad++; $display("FAIL collide_disp_rd got addr=%0d we=%b h=%0d want 2/0/642", acc_addr[1], acc_we[1], acc_h[1]); end
    set_pos(799, 50);
    cyc();
    total++; if (o_RowIdx !== 5'd2 || o_RowBits !== pat(2)) begin
      bad++; $display("FAIL collide_row got %h/%0d want %h/2", o_RowBits, o_RowIdx, pat(2)); end
    $display("test_game_collide: done");
  endtask

  task automatic test_game_write();
    set_pos(100, 60); acc_n = 0; ack_n = 0;
    i_GReq = 1'b1; i_GWe = 1'b1; i_GRow = 5'd3; i_GData = 40'hA5A5A5A5A5;
    repeat (4) cyc();
    i_GWe = 1'b0;
    total++; if (acc_n !== 1 || acc_we[0] !== 1'b1 || acc_addr[0] !== 5'd3 || acc_h[0] !== 101) begin
      bad++; $display("FAIL wr_access got n=%0d we=%b addr=%0d h=%0d want 1/1/3/101", acc_n, acc_we[0], acc_addr[0], acc_h[0]); end
    total++; if (ack_n !== 1 || ack_h !== 102 || ack_data !== 40'd0) begin
      bad++; $display("FAIL wr_ack got n=%0d h=%0d d=%h want 1/102/0", ack_n, ack_h, ack_data); end
    do_line(60);
    total++; if (o_RowIdx !== 5'd3 || o_RowBits !== 40'hA5A5A5A5A5) begin
      bad++; $display("FAIL wr_visible got %h/%0d want a5a5a5a5a5/3", o_RowBits, o_RowIdx); end
    $display("test_game_write: done");
  endtask

  task automatic test_game_invalid();
    set_pos(100, 70); acc_n = 0; ack_n = 0;
    i_GReq = 1'b1; i_GWe = 1'b0; i_GRow = 5'd31;
    repeat (4) cyc();
    total++; if (acc_n !== 0) begin
      bad++; $display("FAIL inv_access got %0d want 0", acc_n); end
    total++; if (ack_n !== 1 || ack_h !== 102 || ack_data !== 40'd0) begin
      bad++; $display("FAIL inv_ack got n=%0d h=%0d d=%h want 1/102/0", ack_n, ack_h, ack_data); end
    $display("test_game_invalid: done");
  endtask

  task automatic test_normal_frame();
    i_MazeLevel = 2'b01;
    do_line(524);
    for (int v = 0; v < 50; v++) do_line(v);
    test_game_collide();
    for (int v = 51; v < 60; v++) do_line(v);
    test_game_write();
    for (int v = 61; v < 70; v++) do_line(v);
    test_game_invalid();
    for (int v = 70; v < 200; v++) do_line(v);
    i_MazeLevel = 2'b10;
    for (int v = 200; v < 220; v++) do_line(v);
    total++; if (o_RowIdx !== 5'd11) begin
      bad++; $display("FAIL lvl_line220 got %0d want 11", o_RowIdx); end
    for (int v = 220; v < 479; v++) do_line(v);
    total++; if (o_RowIdx !== 5'd23) begin
      bad++; $display("FAIL lvl_line479 got %0d want 23", o_RowIdx); end
    for (int v = 479; v < 525; v++) do_line(v);
    for (int v = 0; v < 15; v++) do_line(v);
    total++; if (o_RowIdx !== 5'd0) begin
      bad++; $display("FAIL lvl_new_line15 got %0d want 0", o_RowIdx); end
    do_line(15);
    total++; if (o_RowIdx !== 5'd1 || o_RowBits !== pat(1)) begin
      bad++; $display("FAIL lvl_new_line16 got %h/%0d want %h/1", o_RowBits, o_RowIdx, pat(1)); end
    $display("test_normal_frame: done");
  endtask

  task automatic test_reset_mid();
    set_pos(638, 16); acc_n = 0; ack_n = 0;
    repeat (3) cyc();
    total++; if (o_MemEn !== 1'b1) begin
      bad++; $display("FAIL midrst_disp_rd got en=%b want 1", o_MemEn); end
    cyc();
    i_Rst = 1'b0; i_GReq = 1'b1; i_GWe = 1'b0; i_GRow = 5'd4;
    cyc();
    total++; if (o_MemEn !== 1'b0 || o_GAck !== 1'b0 || o_GRdData !== 40'd0 || o_MemAddr !== 5'd0) begin
      bad++; $display("FAIL midrst_outputs got en=%b ack=%b rd=%h addr=%0d want 0", o_MemEn, o_GAck, o_GRdData, o_MemAddr); end
    total++; if (o_RowBits !== 40'd0 || o_RowIdx !== 5'd0) begin
      bad++; $display("FAIL midrst_row got %h/%0d want 0/0", o_RowBits, o_RowIdx); end
    i_Rst = 1'b1; ack_n = 0;
    repeat (3) cyc();
    total++; if (ack_n !== 1 || ack_h !== 645 || ack_data !== pat(4)) begin
      bad++; $display("FAIL midrst_regrant got n=%0d h=%0d d=%h want 1/645/%h", ack_n, ack_h, ack_data, pat(4)); end
    set_pos(799, 16);
    cyc();
    total++; if (o_RowBits !== 40'd0 || o_RowIdx !== 5'd0) begin
      bad++; $display("FAIL midrst_abandoned got %h/%0d want 0/0", o_RowBits, o_RowIdx); end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_easy_frame();
    test_hard_frame();
    test_normal_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
